// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, data width and baud divider helper.
package uart_pkg;

  localparam int unsigned UartDataW = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } uart_rx_state_e;

  function automatic int unsigned clks_per_bit(input int unsigned freq, input int unsigned baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with push/pop, full/empty flags and occupancy level.
// A push while full is accepted only if a pop happens in the same cycle.
module uart_sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  logic [Width-1:0]             wdata_i,
  input  logic                         pop_i,
  output logic [Width-1:0]             rdata_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(Depth+1)-1:0]   level_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned LvlW = $clog2(Depth+1);

  if ((Depth < 2) || ((Depth & (Depth - 1)) != 0)) begin : g_depth_check
    $error("uart_sync_fifo: Depth must be a power of two >= 2");
  end

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [LvlW-1:0]  level_q;
  logic             push_ok;
  logic             pop_ok;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LvlW'(Depth));
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: 2-FF synchronizer, mid-bit sampling FSM and receive FIFO with valid/ready pop.
// Optional even-parity bit enabled by defining UART_RX_PARITY_EN (default build is 8N1).
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned ClockFrequency = 125_000_000,
  parameter int unsigned BaudRate       = 15_625_000,
  parameter int unsigned FifoDepth      = 8
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               rx_i,
  output logic [UartDataW-1:0]               rx_data_o,
  output logic                               rx_valid_o,
  input  logic                               rx_ready_i,
  output logic [$clog2(FifoDepth+1)-1:0]     rx_level_o,
  output logic                               overflow_o,
  output logic                               frame_err_o
);

  localparam int unsigned ClksPerBit = clks_per_bit(ClockFrequency, BaudRate);
  localparam int unsigned CntW       = $clog2(ClksPerBit);
  localparam logic [CntW-1:0] LastCnt = CntW'(ClksPerBit - 1);
  localparam logic [CntW-1:0] HalfCnt = CntW'(ClksPerBit / 2 - 1);

  if (ClksPerBit < 4) begin : g_cpb_check
    $error("uart_rx_core: ClksPerBit must be >= 4");
  end

  logic [1:0]           sync_q;
  logic                 rx_sync;
  logic                 prev_q;
  uart_rx_state_e       state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 cnt_clr;
  logic                 bit_tick;
  logic [2:0]           bit_q;
  logic [UartDataW-1:0] shift_q;
  logic                 shift_en;
  logic                 push_req;
  logic                 ferr;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 stop_bad;

  assign rx_sync  = sync_q[1];
  assign bit_tick = (cnt_q == LastCnt);

`ifdef UART_RX_PARITY_EN
  logic par_sample;
  logic par_err_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      par_err_q <= 1'b0;
    end else if (par_sample) begin
      par_err_q <= rx_sync ^ (^shift_q);
    end
  end

  // A parity mismatch is reported at the stop sample, so one flag covers both errors.
  assign stop_bad = ~rx_sync | par_err_q;
`else
  assign stop_bad = ~rx_sync;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_clr  = 1'b0;
    shift_en = 1'b0;
    push_req = 1'b0;
    ferr     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_sample = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        cnt_clr = 1'b1;
        if (prev_q && !rx_sync) state_d = START;
      end
      START: begin
        if (cnt_q == HalfCnt) begin
          cnt_clr = 1'b1;
          state_d = rx_sync ? IDLE : DATA;
        end
      end
      DATA: begin
        if (bit_tick) begin
          shift_en = 1'b1;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (bit_tick) begin
          par_sample = 1'b1;
          state_d    = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_tick) begin
          ferr     = stop_bad;
          push_req = ~stop_bad;
          state_d  = rx_sync ? IDLE : BREAK;
        end
      end
      BREAK: begin
        cnt_clr = 1'b1;
        if (rx_sync) state_d = IDLE;
      end
      default: begin
        cnt_clr = 1'b1;
        state_d = IDLE;
      end
    endcase
    cnt_d = (cnt_clr || bit_tick) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q      <= '0;
      prev_q      <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      frame_err_o <= 1'b0;
      overflow_o  <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], rx_i};
      prev_q      <= rx_sync;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      if (state_q == IDLE) begin
        bit_q <= '0;
      end else if (shift_en) begin
        bit_q   <= bit_q + 1'b1;
        shift_q <= {rx_sync, shift_q[UartDataW-1:1]};
      end
      frame_err_o <= ferr;
      // When full the head is valid, so a pop happens exactly when ready is high.
      overflow_o  <= push_req & fifo_full & ~rx_ready_i;
    end
  end

  uart_sync_fifo #(
    .Width (UartDataW),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push_req),
    .wdata_i (shift_q),
    .pop_i   (rx_ready_i),
    .rdata_o (rx_data_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (rx_level_o)
  );

  assign rx_valid_o = ~fifo_empty;

endmodule
